// File: rtl/nibble_serial_addsub.sv
// Nibble-serial WIDTH-bit adder/subtractor: one 4-bit ripple slice reused
// over N=WIDTH/4 cycles, LSB nibble first, with a start/busy/done handshake.
// Ports: clk, rst_n (async low), start, sub, a, b -> busy, done, s, co, ovf.

module ripple_add (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + {4'b0, ci};
endmodule

module nibble_serial_addsub #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);
  localparam int N  = WIDTH / 4;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  generate
    if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_bad_width
      $error("WIDTH must be a multiple of 4 and at least 4");
    end
  endgenerate

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry;
  logic [IW-1:0]    idx;
  logic [3:0]       sl_s;
  logic             sl_co;

  ripple_add u_slice (
    .a  (a_q[4*idx +: 4]),
    .b  (b_q[4*idx +: 4]),
    .ci (carry),
    .s  (sl_s),
    .co (sl_co)
  );

  // Subtraction is a + ~b + 1: the +1 enters as the initial carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      carry <= 1'b0;
      idx   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      s     <= '0;
      co    <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= sub ? ~b : b;
            carry <= sub;
            idx   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          s[4*idx +: 4] <= sl_s;
          carry         <= sl_co;
          if (idx == IW'(N - 1)) begin
            co    <= sl_co;
            // carry into MSB xor carry out of MSB
            ovf   <= a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ sl_s[3] ^ sl_co;
            busy  <= 1'b0;
            done  <= 1'b1;
            idx   <= '0;
            state <= IDLE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Testbench for nibble_serial_addsub: table vectors plus hand sequences,
// results checked through per-instance expectation queues.

module tb_nibble_serial_addsub;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, sub;
  logic [15:0] a, b, s;
  logic        busy, done, co, ovf;
  logic        start4, sub4;
  logic [3:0]  a4, b4, s4;
  logic        busy4, done4, co4, ovf4;

  always #5 clk = ~clk;

  nibble_serial_addsub #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub),
    .a(a), .b(b), .busy(busy), .done(done),
    .s(s), .co(co), .ovf(ovf)
  );

  nibble_serial_addsub #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub4),
    .a(a4), .b(b4), .busy(busy4), .done(done4),
    .s(s4), .co(co4), .ovf(ovf4)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] s;
    logic        co;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [15:0] s;
    logic        co;
    logic        ovf;
  } exp_t;

  exp_t q16[$];
  exp_t q4[$];
  int   checks = 0;
  int   fails  = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (q16.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_done16: got done=1 expected none");
      end else begin
        e = q16.pop_front();
        chk("s16", 32'(s), 32'(e.s));
        chk("co16", 32'(co), 32'(e.co));
        chk("ovf16", 32'(ovf), 32'(e.ovf));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && done4 === 1'b1) begin
      if (q4.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_done4: got done=1 expected none");
      end else begin
        e = q4.pop_front();
        chk("s4", 32'(s4), 32'(e.s));
        chk("co4", 32'(co4), 32'(e.co));
        chk("ovf4", 32'(ovf4), 32'(e.ovf));
      end
    end
  end

  // Called just after a negedge; returns 1ns after the sampling edge.
  task automatic issue(input logic [15:0] xa, input logic [15:0] xb,
                       input logic xs, input exp_t e);
    start = 1'b1;
    a     = xa;
    b     = xb;
    sub   = xs;
    q16.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int n);
    int cyc = 0;
    int bc  = 0;
    bit seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (busy === 1'b1) bc++;
      cyc++;
    end
    chk({nm, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({nm, "_latency"}, 32'(cyc), 32'(n));
      chk({nm, "_busy_cycles"}, 32'(bc), 32'(n));
      chk({nm, "_busy_at_done"}, 32'(busy), 32'd0);
    end
  endtask

  vec_t vecs[7];
  exp_t e;
  int   dc;

  initial begin
    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[2] = '{16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[3] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[4] = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0};
    vecs[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};

    rst_n  = 1'b0;
    start  = 1'b0;
    sub    = 1'b0;
    a      = '0;
    b      = '0;
    start4 = 1'b0;
    sub4   = 1'b0;
    a4     = '0;
    b4     = '0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_s", 32'(s), 32'd0);
    chk("rst_co", 32'(co), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      e = '{vecs[i].s, vecs[i].co, vecs[i].ovf};
      issue(vecs[i].a, vecs[i].b, vecs[i].sub, e);
      wait_done($sformatf("v%0d", i), 4);
    end

    // Back-to-back: start in the done cycle, then a junk start during RUN.
    issue(16'h0010, 16'h0020, 1'b0, '{16'h0030, 1'b0, 1'b0});
    @(negedge clk);
    start = 1'b1;
    a     = 16'hFFFF;
    b     = 16'hFFFF;
    sub   = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("b2b", 3);
    repeat (3) @(negedge clk);

    // Reset in the middle of an operation.
    start = 1'b1;
    a     = 16'h1234;
    b     = 16'h1111;
    sub   = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_s", 32'(s), 32'd0);
    chk("midrst_co", 32'(co), 32'd0);
    chk("midrst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dc = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done === 1'b1) dc++;
    end
    chk("midrst_no_done", 32'(dc), 32'd0);

    // WIDTH=4 instance: single-cycle RUN.
    @(negedge clk);
    start4 = 1'b1;
    a4     = 4'h9;
    b4     = 4'h8;
    sub4   = 1'b0;
    q4.push_back('{16'h0001, 1'b1, 1'b1});
    @(posedge clk);
    #1 start4 = 1'b0;
    @(negedge clk);
    chk("w4_busy", 32'(busy4), 32'd1);
    chk("w4_done_early", 32'(done4), 32'd0);
    @(negedge clk);
    chk("w4_done", 32'(done4), 32'd1);
    start4 = 1'b1;
    a4     = 4'h7;
    b4     = 4'h1;
    sub4   = 1'b1;
    q4.push_back('{16'h0006, 1'b1, 1'b0});
    @(posedge clk);
    #1 start4 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("w4_done2", 32'(done4), 32'd1);

    repeat (3) @(negedge clk);
    chk("q16_empty", 32'(q16.size()), 32'd0);
    chk("q4_empty", 32'(q4.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end
endmodule

// File: doc/nibble_serial_addsub.md
Name: nibble_serial_addsub

Overview:
Multi-cycle WIDTH-bit adder/subtractor built from one 4-bit carry-in/carry-out adder slice (existing ripple_add: a[3:0], b[3:0], ci -> s[3:0], co). It processes one nibble per clock, LSB nibble first, and holds the inter-nibble carry in a flop. This trades latency for area, so wide operands reuse the small ripple slice instead of a full-width adder. Start/busy/done handshake toward the issuing datapath.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4 (elaboration error otherwise)
N (localparam), WIDTH/4, number of nibble steps

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only when busy=0
sub  input  1  0 = a+b, 1 = a-b; sampled with start
a  input  WIDTH  operand A; sampled with start
b  input  WIDTH  operand B; sampled with start
busy  output  1  operation in progress
done  output  1  one-cycle pulse: result valid
s  output  WIDTH  sum/difference, registered
co  output  1  final carry out (for sub: 1 = no borrow)
ovf  output  1  two's-complement signed overflow

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy=0, done=0, s=0, co=0, ovf=0, carry flop=0, nibble index=0, operand registers=0. Release is synchronous to clk. A reset mid-operation aborts it with no done pulse.
- FSM states:
  - IDLE -> RUN on clock edge with start=1. Latch A=a, B=(sub ? ~b : b), carry=sub, idx=0, busy=1, done=0. Do not clear s.
  - RUN: each edge, slice inputs are A[4*idx+:4], B[4*idx+:4] and carry. Write the slice sum into s[4*idx+:4], write slice co into carry, then idx+1.
  - RUN -> IDLE on the edge that processes idx=N-1. On that edge: co <= slice co; ovf <= A[W-1]^B[W-1]^sum[W-1]^slice co, where sum[W-1] is the new s MSB (carry-into-MSB xor carry-out); busy <= 0; done <= 1.
- done is high for exactly one cycle, which is the first IDLE cycle. start=1 in that cycle is accepted, so back-to-back operations are allowed with no bubble.
- Latency: start sampled at edge k, done high after edge k+N+... precisely from edge k+N to edge k+N+1. Throughput is one op per N cycles.
- start while busy=1 is ignored; operands and sub changes during RUN have no effect.
- s, co and ovf are valid from the done cycle and hold until the next accepted start. During RUN, s is partially updated and co/ovf hold stale values.
- Arithmetic is modulo 2^WIDTH; co is carry out of bit WIDTH-1; no saturation.
- WIDTH=4 gives N=1: RUN lasts one cycle.

Test Plan:
- Reset mid-op: start a=16'h1234, b=16'h1111, sub=0; assert rst_n=0 after 2 cycles -> busy, done, s, co, ovf all 0 immediately (asynchronous); no done pulse after release.
- Add with full carry ripple: a=16'hFFFF, b=16'h0001, sub=0 -> done exactly 4 cycles after the start edge; s=16'h0000, co=1, ovf=0; busy high for exactly 4 cycles.
- Signed overflow add: a=16'h7FFF, b=16'h0001, sub=0 -> s=16'h8000, co=0, ovf=1.
- Subtract with borrow: a=16'h0003, b=16'h0005, sub=1 -> s=16'hFFFE, co=0, ovf=0. Then a=16'h8000, b=16'h0001, sub=1 -> s=16'h7FFF, co=1, ovf=1.
- Back-to-back and ignored start: pulse start in the done cycle with a=16'h0010, b=16'h0020 -> accepted, s=16'h0030 after 4 more cycles. A start pulse during RUN with different operands does not change the result.
- WIDTH=4 instance: a=4'h9, b=4'h8, sub=0 -> done 1 cycle after start; s=4'h1, co=1, ovf=1.
